// File: rtl/spi_pkg.sv
// Purpose : shared SPI definitions (FSM states, default frame width and synchronizer depth).
// Latency : n/a (types and constants only).
// Backpr. : n/a.
package spi_pkg;

    // Default frame width and synchronizer depth, shared with the SPI master.
    localparam int SPI_DATA_W      = 8;
    localparam int SPI_SYNC_STAGES = 2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Purpose : multi-flop synchronizer for async inputs with single-cycle rise/fall events.
// Latency : o_sync follows the pin after STAGES cycles; the events are valid in that same cycle.
// Backpr. : none; every edge produces exactly one event cycle.
// Ports   : i_clk/i_rst (sync, active-high), i_async (raw pins),
//           o_sync (synchronized level), o_rise / o_fall (one-cycle edge events).
module spi_sync_edge #(
    parameter int               WIDTH   = 1,
    parameter int               STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall
);

    logic [WIDTH-1:0] r_sync [STAGES];
    logic [WIDTH-1:0] r_prev;

    // Reset to the pin's idle level so leaving reset never fakes an edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < STAGES; i++) begin
                r_sync[i] <= RST_VAL;
            end
            r_prev <= RST_VAL;
        end else begin
            r_sync[0] <= i_async;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_sync = r_sync[STAGES-1];
    assign o_rise = o_sync & ~r_prev;
    assign o_fall = ~o_sync & r_prev;

endmodule

// File: rtl/spi_slave.sv
// Purpose : SPI mode-0 responder, MSB-first DATA_W-bit frames, one-deep TX holding register.
// Latency : pin edge to action SYNC_STAGES+1 cycles; MISO and RX_VALID SYNC_STAGES+2 cycles after the pin edge.
// Backpr. : TX accepted only when the holding register is empty; RX has no handshake (overwritten each frame).
// Ports   : i_clk/i_rst (sync, active-high); i_sclk/i_cs_n/i_mosi async SPI pins; o_miso/o_miso_oe;
//           i_tx_data/i_tx_valid/o_tx_ready holding-register write; o_rx_data/o_rx_valid received frame;
//           o_tx_underrun frame started with nothing held; o_busy synchronized chip select.
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_sclk,
    input  logic              i_cs_n,
    input  logic              i_mosi,
    output logic              o_miso,
    output logic              o_miso_oe,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic              i_tx_valid,
    output logic              o_tx_ready,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_rx_valid,
    output logic              o_tx_underrun,
    output logic              o_busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    spi_state_e          r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_tx_shift, r_rx_shift, r_hold, r_rx_data;
    logic                r_hold_full, r_load_pend, r_miso, r_rx_valid, r_tx_underrun;
    logic [SYNC_STAGES-1:0] r_mosi_sync;

    logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
    logic w_cs_sync, w_cs_rise, w_cs_fall;
    logic w_mosi, w_load, w_shift, w_sample, w_abort, w_complete;
    logic w_unused_sclk_lvl;

    spi_sync_edge #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_async(i_sclk),
        .o_sync (w_sclk_sync),
        .o_rise (w_sclk_rise),
        .o_fall (w_sclk_fall)
    );

    spi_sync_edge #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_async(i_cs_n),
        .o_sync (w_cs_sync),
        .o_rise (w_cs_rise),
        .o_fall (w_cs_fall)
    );

    // Only SCLK edges matter; the level is deliberately left unused.
    assign w_unused_sclk_lvl = w_sclk_sync;

    // MOSI needs the level only; same depth keeps it aligned with the SCLK events.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mosi_sync <= '0;
        end else begin
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
        end
    end
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus per-cycle datapath strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_sample    = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_state_nxt = ST_ACTIVE;
                    w_load      = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (w_cs_rise) begin
                    w_state_nxt = ST_IDLE;
                    w_abort     = 1'b1;
                end else begin
                    w_sample = w_sclk_rise;
                    // The first fall after a finished frame loads the next one instead of shifting.
                    if (w_sclk_fall) begin
                        w_load  = r_load_pend;
                        w_shift = ~r_load_pend;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Counter reached DATA_W on the previous rise: shift register already holds the last bit.
    assign w_complete = (r_cnt == CNT_W'(DATA_W));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt         <= '0;
            r_tx_shift    <= '0;
            r_rx_shift    <= '0;
            r_rx_data     <= '0;
            r_hold        <= '0;
            r_hold_full   <= 1'b0;
            r_load_pend   <= 1'b0;
            r_miso        <= 1'b0;
            r_rx_valid    <= 1'b0;
            r_tx_underrun <= 1'b0;
        end else begin
            r_rx_valid    <= 1'b0;
            r_tx_underrun <= 1'b0;

            if (w_sample) begin
                r_rx_shift <= {r_rx_shift[DATA_W-2:0], w_mosi};
                r_cnt      <= r_cnt + CNT_W'(1);
            end

            if (w_complete) begin
                r_rx_data   <= r_rx_shift;
                r_rx_valid  <= 1'b1;
                r_cnt       <= '0;
                r_load_pend <= 1'b1;
            end

            // Load uses the holding state from before any same-cycle write.
            if (w_load) begin
                r_load_pend <= 1'b0;
                if (r_hold_full) begin
                    r_tx_shift  <= r_hold;
                    r_hold_full <= 1'b0;
                end else begin
                    r_tx_shift    <= '0;
                    r_tx_underrun <= 1'b1;
                end
            end else if (w_shift) begin
                r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
            end

            // Deselect mid-frame drops the partial frame; the holding register survives.
            if (w_abort) begin
                r_cnt       <= '0;
                r_load_pend <= 1'b0;
                r_tx_shift  <= '0;
            end

            if (i_tx_valid && !r_hold_full) begin
                r_hold      <= i_tx_data;
                r_hold_full <= 1'b1;
            end

            r_miso <= (r_state == ST_ACTIVE) ? r_tx_shift[DATA_W-1] : 1'b0;
        end
    end

    assign o_miso        = r_miso;
    assign o_miso_oe     = (r_state == ST_ACTIVE);
    assign o_tx_ready    = ~r_hold_full;
    assign o_rx_data     = r_rx_data;
    assign o_rx_valid    = r_rx_valid;
    assign o_tx_underrun = r_tx_underrun;
    assign o_busy        = ~w_cs_sync;

endmodule
